// File: rtl/clock_pkg.sv
// Shared encodings and widths for the time-set sequencer.
package clock_pkg;

  localparam int HRS_W   = 5;
  localparam int MS_W    = 6;
  localparam int HRS_MAX = 23;
  localparam int MIN_MAX = 59;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HRS = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    LOAD    = 3'd4
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HRS  = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  function automatic logic is_edit(input state_t s);
    return (s == SET_HRS) || (s == SET_MIN) || (s == SET_SEC);
  endfunction

endpackage

// File: rtl/clock_set_controller_wrap_counter.sv
// Registered up/down field with wrap at MAX; out-of-range values wrap to 0 on any step.
module wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && !dec) begin
      q <= (q >= MAXV) ? '0 : q + W'(1);
    end else if (dec && !inc) begin
      // a captured out-of-range value snaps to 0 rather than stepping down
      if (q > MAXV)       q <= '0;
      else if (q == '0)   q <= MAXV;
      else                q <= q - W'(1);
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Edit-session sequencer: captures live time, steps hrs/min/sec fields, loads the core.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int BLINK_CYCLES  = 50_000_000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [HRS_W-1:0]  cur_hrs,
  input  logic [MS_W-1:0]   cur_min,
  input  logic [MS_W-1:0]   cur_sec,
  output logic [HRS_W-1:0]  set_hrs,
  output logic [MS_W-1:0]   set_min,
  output logic [MS_W-1:0]   set_sec,
  output logic              load_time,
  output logic              edit_active,
  output logic [1:0]        edit_field,
  output logic              blank_field
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t        state;
  logic [TW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic capture, inc, dec, field_entry;

  // mode wins over up/down; up and down together cancel
  assign inc         = btn_up & ~btn_down & ~btn_mode;
  assign dec         = btn_down & ~btn_up & ~btn_mode;
  assign capture     = (state == RUN) & btn_mode;
  assign field_entry = btn_mode & ((state == RUN) | (state == SET_HRS) | (state == SET_MIN));

  wrap_counter #(.W(HRS_W), .MAX(HRS_MAX)) u_hrs (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .load_val (cur_hrs),
    .inc      (inc & (state == SET_HRS)),
    .dec      (dec & (state == SET_HRS)),
    .q        (set_hrs)
  );

  wrap_counter #(.W(MS_W), .MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .load_val (cur_min),
    .inc      (inc & (state == SET_MIN)),
    .dec      (dec & (state == SET_MIN)),
    .q        (set_min)
  );

  wrap_counter #(.W(MS_W), .MAX(MIN_MAX)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .load_val (cur_sec),
    .inc      (inc & (state == SET_SEC)),
    .dec      (dec & (state == SET_SEC)),
    .q        (set_sec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      load_time   <= 1'b0;
      edit_field  <= FLD_NONE;
      edit_active <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      load_time <= 1'b0;
      case (state)
        RUN: begin
          if (btn_mode) begin
            state       <= SET_HRS;
            edit_field  <= FLD_HRS;
            edit_active <= 1'b1;
            idle_cnt    <= '0;
          end
        end
        SET_HRS, SET_MIN, SET_SEC: begin
          if (btn_mode) begin
            idle_cnt <= '0;
            case (state)
              SET_HRS: begin state <= SET_MIN; edit_field <= FLD_MIN; end
              SET_MIN: begin state <= SET_SEC; edit_field <= FLD_SEC; end
              default: begin
                state       <= LOAD;
                load_time   <= 1'b1;
                edit_field  <= FLD_NONE;
                edit_active <= 1'b0;
              end
            endcase
          end else if (btn_up | btn_down) begin
            idle_cnt <= '0;
          end else if (tick_1hz) begin
            if (idle_cnt == TW'(TIMEOUT_TICKS - 1)) begin
              state       <= RUN;
              edit_field  <= FLD_NONE;
              edit_active <= 1'b0;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end
        end
        LOAD:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // restart the blink on each field change so the new field is shown first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (field_entry) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blank_field = phase & edit_active;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboarded bench for clock_set_controller: loads checked against queued expectations.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [4:0] cur_hrs = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic [4:0] set_hrs;
  logic [5:0] set_min, set_sec;
  logic       load_time, edit_active, blank_field;
  logic [1:0] edit_field;

  int ntests = 0;
  int nfail  = 0;
  int load_cnt = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  clock_set_controller #(.BLINK_CYCLES(4), .TIMEOUT_TICKS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .cur_hrs     (cur_hrs),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .set_hrs     (set_hrs),
    .set_min     (set_min),
    .set_sec     (set_sec),
    .load_time   (load_time),
    .edit_active (edit_active),
    .edit_field  (edit_field),
    .blank_field (blank_field)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one-cycle input pulse; returns at the negedge after the sampling edge
  task automatic press(input logic m, input logic u, input logic d, input logic t);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; tick_1hz = t;
    @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; tick_1hz = 1'b0;
  endtask

  always @(negedge clk) begin
    if (load_time) begin
      load_cnt++;
      if (exp_q.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
      else chk("load_value", {15'd0, set_hrs, set_min, set_sec}, {15'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_field", edit_field, 0);
    chk("rst_active", edit_active, 0);
    chk("rst_load", load_time, 0);
    chk("rst_set", {set_hrs, set_min, set_sec}, 0);
    chk("rst_blank", blank_field, 0);
    rst_n = 1'b1;

    // capture and load with no edits
    cur_hrs = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    press(1, 0, 0, 0);
    chk("t1_field_h", edit_field, 1);
    chk("t1_active", edit_active, 1);
    chk("t1_capture", {set_hrs, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
    press(1, 0, 0, 0);
    chk("t1_field_m", edit_field, 2);
    press(1, 0, 0, 0);
    chk("t1_field_s", edit_field, 3);
    exp_q.push_back({5'd12, 6'd34, 6'd56});
    press(1, 0, 0, 0);
    chk("t1_load_hi", load_time, 1);
    chk("t1_field_0", edit_field, 0);
    @(negedge clk);
    chk("t1_load_lo", load_time, 0);
    repeat (3) @(negedge clk);
    chk("t1_load_cnt", load_cnt, 1);
    chk("t1_hold", {set_hrs, set_min, set_sec}, {5'd12, 6'd34, 6'd56});

    // hour/minute/second wraps, cancel, mode-wins
    cur_hrs = 5'd23; cur_min = 6'd59; cur_sec = 6'd0;
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    chk("t2_hrs_up_wrap", set_hrs, 0);
    press(0, 0, 1, 0);
    chk("t2_hrs_dn_wrap", set_hrs, 23);
    press(0, 0, 1, 0);
    chk("t2_hrs_dn", set_hrs, 22);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    chk("t3_min_up_wrap", set_min, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    chk("t3_sec_dn_wrap", set_sec, 59);
    press(0, 1, 1, 0);
    chk("t3_updown", set_sec, 59);
    exp_q.push_back({5'd22, 6'd0, 6'd59});
    press(1, 1, 0, 0);
    chk("t3_mode_wins", load_time, 1);
    @(negedge clk);

    // timeout abort, out-of-range capture
    cur_hrs = 5'd30;
    press(1, 0, 0, 0);
    chk("t4_oor_capture", set_hrs, 30);
    press(0, 1, 0, 0);
    chk("t4_oor_wrap", set_hrs, 0);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk("t4_before_to", edit_active, 1);
    press(0, 0, 0, 1);
    chk("t4_timeout_active", edit_active, 0);
    chk("t4_timeout_field", edit_field, 0);
    // button on the expiring tick keeps the session alive
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    press(0, 1, 0, 1);
    chk("t4_saved_field", edit_field, 1);
    chk("t4_saved_hrs", set_hrs, 1);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk("t4_still_active", edit_active, 1);
    press(0, 0, 0, 1);
    chk("t4_second_to", edit_active, 0);
    chk("t4_no_load", load_cnt, 2);

    // reset mid-session
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("t5_in_min", edit_field, 2);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("t5_field", edit_field, 0);
    chk("t5_active", edit_active, 0);
    chk("t5_set", {set_hrs, set_min, set_sec}, 0);
    chk("t5_load", load_time, 0);

    // blink: 4 cycles shown, 4 blanked, cleared on field change
    cur_hrs = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
    press(1, 0, 0, 0);
    for (k = 0; k < 6; k++) begin
      chk($sformatf("t6_blink_%0d", k), blank_field, (k / 4) % 2);
      if (k < 5) @(negedge clk);
    end
    press(1, 0, 0, 0);
    chk("t6_field_chg", blank_field, 0);
    chk("t6_field_m", edit_field, 2);
    press(1, 0, 0, 0);
    exp_q.push_back({5'd5, 6'd6, 6'd7});
    press(1, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("t6_run_blank", blank_field, 0);
    end
    chk("end_load_cnt", load_cnt, 3);
    chk("end_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
